// File: rtl/video_pattern_gen.sv
// Synthetic fvh/dv/pixel video source drawing a programmable FG rectangle on BG.
// Optional define NOISE_PIXEL_EN adds LFSR speckle to the background.
module video_pattern_gen #(
  parameter int         LINE_CLKS       = 1716,
  parameter int         H_ACT_START     = 244,
  parameter int         ACT_PIX         = 720,
  parameter int         DV_DIV          = 2,
  parameter int         LINES_PER_FIELD = 262,
  parameter int         V_ACT_START     = 20,
  parameter int         ACT_LINES       = 240,
  parameter logic [7:0] FG              = 8'hFF,
  parameter logic [7:0] BG              = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  input  logic [10:0] half_w,
  input  logic [9:0]  half_h,
  output logic [2:0]  fvh,
  output logic        dv,
  output logic [7:0]  pixel,
  output logic [7:0]  frame_cnt
);

  localparam int HW  = $clog2(LINE_CLKS);
  localparam int HW1 = HW + 1;
  localparam int LW  = $clog2(LINES_PER_FIELD);
  localparam int LW1 = LW + 1;
  localparam int PW  = (DV_DIV > 1) ? $clog2(DV_DIV) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_CLKS - 1);
  localparam logic [HW:0]   H_ACT_LO  = HW1'(H_ACT_START);
  localparam logic [HW:0]   H_ACT_HI  = HW1'(H_ACT_START + ACT_PIX * DV_DIV);
  localparam logic [LW-1:0] L_LAST    = LW'(LINES_PER_FIELD - 1);
  localparam logic [LW-1:0] V_LO      = LW'(V_ACT_START);
  localparam logic [LW:0]   V_ACT_LO  = LW1'(V_ACT_START);
  localparam logic [LW:0]   V_ACT_HI  = LW1'(V_ACT_START + ACT_LINES);
  localparam logic [PW-1:0] P_LAST    = PW'(DV_DIV - 1);
  localparam logic [11:0]   X_MAX     = 12'(ACT_PIX - 1);
  localparam logic [10:0]   Y_MAX     = 11'(2 * ACT_LINES - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_h, w_h_nxt;
  logic [LW-1:0] r_line, w_line_nxt;
  logic          r_field, w_field_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic [10:0]   r_col, w_col_nxt;

  logic [11:0]   r_x_lo, r_x_hi;
  logic [10:0]   r_y_lo, r_y_hi;
  logic [2:0]    r_fvh;
  logic          r_dv;
  logic [7:0]    r_pixel;
  logic [7:0]    r_frame_cnt;

  logic          w_eol, w_last_clk, w_running_nxt;
  logic          w_sol_nxt, w_sof_nxt, w_act_nxt, w_dv_nxt, w_in_box;
  logic [10:0]   w_row_nxt;
  logic [11:0]   w_x_sum, w_x_lo_new, w_x_hi_new, w_x_lo, w_x_hi;
  logic [10:0]   w_y_sum, w_y_lo_new, w_y_hi_new, w_y_lo, w_y_hi;
  logic [7:0]    w_pix_nxt;

  assign w_eol      = (r_h == H_LAST);
  assign w_last_clk = w_eol && (r_line == L_LAST);

  // NOTE: every signal assigned in an always_comb gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (run) w_state_nxt = S_RUN;
      S_RUN:      if (!run) w_state_nxt = w_last_clk ? S_IDLE : S_STOPPING;
      S_STOPPING: begin
        if (run)             w_state_nxt = S_RUN;
        else if (w_last_clk) w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Counters restart from zero on IDLE exit; the pixel phase/column realign at H_ACT_START.
  always_comb begin
    w_h_nxt     = '0;
    w_line_nxt  = '0;
    w_field_nxt = 1'b0;
    w_phase_nxt = '0;
    w_col_nxt   = '0;
    if (r_state != S_IDLE && w_state_nxt != S_IDLE) begin
      w_h_nxt     = w_eol ? '0 : r_h + HW'(1);
      w_line_nxt  = r_line;
      w_field_nxt = r_field;
      if (w_eol) begin
        w_line_nxt = (r_line == L_LAST) ? '0 : r_line + LW'(1);
        if (r_line == L_LAST) w_field_nxt = ~r_field;
      end
      if ({1'b0, w_h_nxt} != H_ACT_LO) begin
        w_phase_nxt = (r_phase == P_LAST) ? '0 : r_phase + PW'(1);
        w_col_nxt   = r_col + 11'(r_phase == P_LAST);
      end
    end
  end

  assign w_running_nxt = (w_state_nxt != S_IDLE);
  assign w_sol_nxt     = w_running_nxt && (w_h_nxt == '0);
  assign w_sof_nxt     = w_sol_nxt && (w_line_nxt == '0);
  assign w_act_nxt     = w_running_nxt &&
                         ({1'b0, w_h_nxt} >= H_ACT_LO) && ({1'b0, w_h_nxt} < H_ACT_HI) &&
                         ({1'b0, w_line_nxt} >= V_ACT_LO) && ({1'b0, w_line_nxt} < V_ACT_HI);
  assign w_dv_nxt      = w_act_nxt && (w_phase_nxt == '0);
  assign w_row_nxt     = 11'({w_line_nxt - V_LO, 1'b0});

  // Sums are one bit wider than the operands so the clamp never sees a wrapped value.
  assign w_x_sum    = {1'b0, cx} + {1'b0, half_w};
  assign w_x_lo_new = (cx < half_w) ? '0 : {1'b0, cx - half_w};
  assign w_x_hi_new = (w_x_sum > X_MAX) ? X_MAX : w_x_sum;
  assign w_y_sum    = {1'b0, cy} + {1'b0, half_h};
  assign w_y_lo_new = (cy < half_h) ? '0 : {1'b0, cy - half_h};
  assign w_y_hi_new = (w_y_sum > Y_MAX) ? Y_MAX : w_y_sum;

  // Fresh bounds apply on the latching clock itself in case the active area starts at (0,0).
  assign w_x_lo = w_sof_nxt ? w_x_lo_new : r_x_lo;
  assign w_x_hi = w_sof_nxt ? w_x_hi_new : r_x_hi;
  assign w_y_lo = w_sof_nxt ? w_y_lo_new : r_y_lo;
  assign w_y_hi = w_sof_nxt ? w_y_hi_new : r_y_hi;

  assign w_in_box = ({1'b0, w_col_nxt} >= w_x_lo) && ({1'b0, w_col_nxt} <= w_x_hi) &&
                    (w_row_nxt >= w_y_lo) && (w_row_nxt <= w_y_hi);

`ifdef NOISE_PIXEL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_lfsr <= 16'hACE1;
    else if (w_dv_nxt) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
  end

  assign w_pix_nxt = (w_in_box || (r_lfsr[7:0] == 8'h00)) ? FG : BG;
`else
  assign w_pix_nxt = w_in_box ? FG : BG;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_h         <= '0;
      r_line      <= '0;
      r_field     <= 1'b0;
      r_phase     <= '0;
      r_col       <= '0;
      r_x_lo      <= '0;
      r_x_hi      <= '0;
      r_y_lo      <= '0;
      r_y_hi      <= '0;
      r_fvh       <= 3'b000;
      r_dv        <= 1'b0;
      r_pixel     <= 8'h00;
      r_frame_cnt <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_line  <= w_line_nxt;
      r_field <= w_field_nxt;
      r_phase <= w_phase_nxt;
      r_col   <= w_col_nxt;
      r_fvh   <= {w_field_nxt, w_sof_nxt, w_sol_nxt};
      r_dv    <= w_dv_nxt;
      if (w_dv_nxt) r_pixel <= w_pix_nxt;
      if (r_state != S_IDLE && w_last_clk) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_sof_nxt) begin
        r_x_lo <= w_x_lo_new;
        r_x_hi <= w_x_hi_new;
        r_y_lo <= w_y_lo_new;
        r_y_hi <= w_y_hi_new;
      end
    end
  end

  assign fvh       = r_fvh;
  assign dv        = r_dv;
  assign pixel     = r_pixel;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: box shapes, clipping, field timing, stop, reset, wrap.
// Build with NOISE_PIXEL_EN defined to also model the background speckle.
module tb_video_pattern_gen;

  localparam int LINE_CLKS = 40;
  localparam int ACT_PIX   = 12;
  localparam int ACT_LINES = 6;

`ifdef NOISE_PIXEL_EN
  localparam bit NOISE = 1'b1;
`else
  localparam bit NOISE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, run, run_w;
  logic [10:0] cx, half_w;
  logic [9:0]  cy, half_h;
  logic [2:0]  fvh, fvh_w;
  logic        dv, dv_w;
  logic [7:0]  pixel, pixel_w, frame_cnt, frame_cnt_w;

  int          n_checks = 0;
  int          n_errors = 0;
  int          t;
  bit          sb_q[$];
  int          dv_total = 0, fg_total = 0, noise_hits = 0;
  int          dv_s, fg_s, nh_s;
  logic [15:0] m_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .LINE_CLKS(40), .H_ACT_START(8), .ACT_PIX(12), .DV_DIV(2),
    .LINES_PER_FIELD(10), .V_ACT_START(2), .ACT_LINES(6)
  ) u_dut (
    .clk(clk), .reset(reset), .run(run), .cx(cx), .cy(cy), .half_w(half_w), .half_h(half_h),
    .fvh(fvh), .dv(dv), .pixel(pixel), .frame_cnt(frame_cnt)
  );

  // Tiny 8-clock field so the frame counter wrap is reachable quickly.
  video_pattern_gen #(
    .LINE_CLKS(4), .H_ACT_START(0), .ACT_PIX(1), .DV_DIV(2),
    .LINES_PER_FIELD(2), .V_ACT_START(0), .ACT_LINES(1)
  ) u_dut_wrap (
    .clk(clk), .reset(reset), .run(run_w), .cx(cx), .cy(cy), .half_w(half_w), .half_h(half_h),
    .fvh(fvh_w), .dv(dv_w), .pixel(pixel_w), .frame_cnt(frame_cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected in-box flag for every dv pulse of one field, in raster order.
  task automatic push_field(input int bcx, input int bcy, input int bhw, input int bhh);
    int xlo, xhi, ylo, yhi;
    xlo = (bcx < bhw) ? 0 : bcx - bhw;
    xhi = (bcx + bhw > ACT_PIX - 1) ? ACT_PIX - 1 : bcx + bhw;
    ylo = (bcy < bhh) ? 0 : bcy - bhh;
    yhi = (bcy + bhh > 2 * ACT_LINES - 2) ? 2 * ACT_LINES - 2 : bcy + bhh;
    for (int l = 0; l < ACT_LINES; l++)
      for (int c = 0; c < ACT_PIX; c++)
        sb_q.push_back(c >= xlo && c <= xhi && 2 * l >= ylo && 2 * l <= yhi);
  endtask

  task automatic step_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic snap();
    dv_s = dv_total;
    fg_s = fg_total;
    nh_s = noise_hits;
  endtask

  task automatic check_field(input string tag, input int exp_fg);
    check({tag, "_dv_count"}, 32'(dv_total - dv_s), 32'(ACT_PIX * ACT_LINES));
    check({tag, "_fg_count"}, 32'(fg_total - fg_s), 32'(exp_fg + noise_hits - nh_s));
    snap();
  endtask

  always @(negedge clk) begin : monitor
    bit         box;
    logic [7:0] exp_pix;
    if (!reset && dv) begin
      dv_total++;
      if (pixel == 8'hFF) fg_total++;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        box     = sb_q.pop_front();
        exp_pix = box ? 8'hFF : 8'h00;
        if (NOISE && !box && m_lfsr[7:0] == 8'h00) begin
          exp_pix = 8'hFF;
          noise_hits++;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
        check("pixel", 32'(pixel), 32'(exp_pix));
      end
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; run_w = 1'b0;
    cx = 11'd5; cy = 10'd4; half_w = 11'd1; half_h = 10'd2;
    t = 0;
    repeat (3) @(negedge clk);
    check("rst_fvh", 32'(fvh), 32'd0);
    check("rst_dv", 32'(dv), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_fvh", 32'(fvh), 32'd0);
    check("idle_dv", 32'(dv), 32'd0);

    // Field 0: box A; field 1 gets B, written mid-field 0.
    push_field(5, 4, 1, 2);
    snap();
    run = 1'b1;
    @(negedge clk);
    t = 0;
    check("first_fvh", 32'(fvh), 32'b011);
    step_to(1);   check("fvh_h1", 32'(fvh), 32'b000);
    step_to(40);  check("fvh_line1", 32'(fvh), 32'b001);
    step_to(87);  check("dv_before_active", 32'(dv), 32'd0);
    step_to(88);  check("dv_first_active", 32'(dv), 32'd1);
    step_to(89);  check("dv_odd_phase", 32'(dv), 32'd0);
    step_to(200);
    cx = 11'd0; half_w = 11'd3; cy = 10'd0; half_h = 10'd0;
    push_field(0, 0, 3, 0);
    step_to(399); check("frame_cnt_f0_busy", 32'(frame_cnt), 32'd0);
    step_to(400);
    check("fvh_field1", 32'(fvh), 32'b111);
    check("frame_cnt_1", 32'(frame_cnt), 32'd1);
    check_field("field0_boxA", 9);

    step_to(600);
    cx = 11'd11; half_w = 11'd5; cy = 10'd6; half_h = 10'd10;
    push_field(11, 6, 5, 10);
    step_to(800);
    check("fvh_field2", 32'(fvh), 32'b011);
    check("frame_cnt_2", 32'(frame_cnt), 32'd2);
    check_field("field1_clip_left", 4);

    step_to(1000);
    cx = 11'd100; half_w = 11'd2; cy = 10'd4; half_h = 10'd2;
    push_field(100, 4, 2, 2);
    step_to(1200);
    check("fvh_field3", 32'(fvh), 32'b111);
    check("frame_cnt_3", 32'(frame_cnt), 32'd3);
    check_field("field2_clip_right", 36);

    // Drop run mid-field: the field completes, then the block idles.
    step_to(1300); run = 1'b0;
    step_to(1599); check("stopping_field_bit", 32'(fvh[2]), 32'd1);
    step_to(1600);
    check("stopped_fvh", 32'(fvh), 32'd0);
    check("stopped_dv", 32'(dv), 32'd0);
    check("frame_cnt_4", 32'(frame_cnt), 32'd4);
    check_field("field3_offscreen", 0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    step_to(1700);
    check("idle_after_stop_fvh", 32'(fvh), 32'd0);
    check("idle_after_stop_frames", 32'(frame_cnt), 32'd4);
    check("idle_no_dv", 32'(dv_total - dv_s), 32'd0);

    // Restart, then assert reset in the middle of an active line.
    cx = 11'd11; half_w = 11'd5; cy = 10'd6; half_h = 10'd10;
    push_field(11, 6, 5, 10);
    run = 1'b1;
    @(negedge clk);
    t = 0;
    check("restart_fvh", 32'(fvh), 32'b011);
    step_to(110);
    check("midline_dv", 32'(dv), 32'd1);
    check("midline_pixel", 32'(pixel), 32'hFF);
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check("async_rst_fvh", 32'(fvh), 32'd0);
    check("async_rst_dv", 32'(dv), 32'd0);
    check("async_rst_pixel", 32'(pixel), 32'd0);
    check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    sb_q.delete();
    m_lfsr = 16'hACE1;
    @(negedge clk);
    reset = 1'b0;

    // Frame counter wrap on the 8-clock-field instance.
    @(negedge clk);
    run_w = 1'b1;
    @(negedge clk);
    t = 0;
    step_to(2040); check("frame_cnt_255", 32'(frame_cnt_w), 32'd255);
    step_to(2048); check("frame_cnt_wrap", 32'(frame_cnt_w), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
